param_password_lock: RTL and testbench

Parametrised successor to the 4-digit password lock FSM: configurable digit count, digit width and attempt limit, with a timed lockout, password reprogramming and gated password view. It sits between the keypad decoder (one `digit` plus `enter` strobe per key) and the LED/alarm drivers. It holds the stored password, checks entered codes, counts failed attempts and enforces lockout.

---
 rtl/password_lock_pkg.sv | 33 +++
 rtl/param_password_lock_lockout_timer.sv | 62 ++++++
 rtl/param_password_lock.sv | 225 ++++++++++++++++++++++
 tb/tb_param_password_lock.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/password_lock_pkg.sv
// ---------------------------------------------------------------------------
// password_lock_pkg
//
// Purpose: shared definitions for the parametrised password lock.
//   - lock_state_t : the seven controller states with a fixed 3-bit encoding.
//     The enumerators double as the state-name constants that benches and
//     debug tooling refer to.
//   - NUM_STATES   : number of states in lock_state_t.
//   - clog2_min1   : width helper that never returns zero, used for counters
//     whose range may collapse to a single value.
//
// No ports (package).
// ---------------------------------------------------------------------------
package password_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_FAIL     = 3'd3,
        ST_UNLOCKED = 3'd4,
        ST_SETPASS  = 3'd5,
        ST_LOCKOUT  = 3'd6
    } lock_state_t;

    localparam int unsigned NUM_STATES = 7;

    // A counter that only ever holds 0 still needs one bit of storage.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/param_password_lock_lockout_timer.sv
// ---------------------------------------------------------------------------
// lockout_timer
//
// Purpose: measures the lockout period for param_password_lock.
//
// Build option: macro LOCKOUT_TIMER_EN.
//   defined     : a counter runs from 0 to LOCKOUT_CYCLES-1 while `start` is
//                 high and `done` pulses in the final cycle, so the owner
//                 spends exactly LOCKOUT_CYCLES cycles in lockout.
//   not defined : no counter is built, `done` is tied low and lockout only
//                 ends on reset. LOCKOUT_CYCLES is unused.
//
// Ports:
//   clk    in  1 : rising-edge clock
//   reset  in  1 : synchronous, active-high; clears the counter
//   start  in  1 : level, high for every cycle the owner is in lockout
//   done   out 1 : high in the last lockout cycle
// ---------------------------------------------------------------------------
module lockout_timer
    import password_lock_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

`ifdef LOCKOUT_TIMER_EN

    localparam int unsigned CW = clog2_min1(LOCKOUT_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(LOCKOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    // The counter sits at zero outside lockout and wraps back to zero on the
    // final cycle, so a fresh lockout always starts from a clean count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (!start || (count_q == LAST_COUNT)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done = start && (count_q == LAST_COUNT);

`else

    // Permanent lockout: the inputs are folded into a sink so the module
    // keeps the same port list in both builds.
    logic unused_timer_inputs;
    assign unused_timer_inputs = ^{clk, reset, start, (LOCKOUT_CYCLES > 0)};

    assign done = 1'b0;

`endif

endmodule

// File: rtl/param_password_lock.sv
// ---------------------------------------------------------------------------
// param_password_lock
//
// Purpose: keypad password lock with configurable code length, digit width
// and attempt limit. Holds the stored password, checks entered codes, counts
// failed attempts, enforces lockout and supports reprogramming and a gated
// password view while unlocked.
//
// Build option: LOCKOUT_TIMER_EN (see lockout_timer). Without it, LOCKOUT
// lasts until reset.
//
// Parameters:
//   DIGITS, DIGIT_W, MAX_ATTEMPTS, LOCKOUT_CYCLES, DEFAULT_PASS
//   (DEFAULT_PASS holds the first digit in the most significant slot)
//
// Ports:
//   clk           in  1        : rising-edge clock
//   reset         in  1        : synchronous, active-high
//   digit         in  DIGIT_W  : key value, taken when enter=1
//   enter         in  1        : one digit accepted per high cycle
//   set_pass      in  1        : request reprogramming (UNLOCKED only)
//   view_pass     in  1        : request password display (UNLOCKED only)
//   lock          in  1        : leave UNLOCKED / abort SETPASS
//   green_led     out 1        : UNLOCKED or SETPASS
//   red_led       out 1        : FAIL or LOCKOUT
//   alarm         out 1        : LOCKOUT
//   viewed_pass   out DIGITS*DIGIT_W : stored password when viewed, else 0
//   attempts_left out clog2(MAX_ATTEMPTS+1) : remaining tries
//   busy          out 1        : CHECK, FAIL or LOCKOUT (enter ignored)
// ---------------------------------------------------------------------------
module param_password_lock
    import password_lock_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PASS = 'h1234
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               enter,
    input  logic                               set_pass,
    input  logic                               view_pass,
    input  logic                               lock,
    output logic                               green_led,
    output logic                               red_led,
    output logic                               alarm,
    output logic [DIGITS*DIGIT_W-1:0]          viewed_pass,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]  attempts_left,
    output logic                               busy
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);
    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);
    localparam logic [ATT_W-1:0] ATT_ONE  = ATT_W'(1);

    lock_state_t        state_q;
    lock_state_t        state_d;
    logic [CODE_W-1:0]  entry_q;
    logic [CODE_W-1:0]  entry_shifted;
    logic [CNT_W-1:0]   count_q;
    logic [CODE_W-1:0]  pass_q;
    logic [ATT_W-1:0]   attempts_q;
    logic               last_digit;
    logic               code_match;
    logic               timer_start;
    logic               timer_done;

    // The entry register shifts left so the first key ends up in the most
    // significant slot, matching how DEFAULT_PASS is written. A one-digit
    // code has nothing to keep, so it simply takes the new digit.
    generate
        if (DIGITS == 1) begin : g_single_digit
            assign entry_shifted = digit;
        end else begin : g_multi_digit
            assign entry_shifted = {entry_q[CODE_W-DIGIT_W-1:0], digit};
        end
    endgenerate

    assign last_digit  = (count_q == LAST_IDX);
    assign code_match  = (entry_q == pass_q);
    assign timer_start = (state_q == ST_LOCKOUT);

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .done  (timer_done)
    );

    // State register. Everything the controller remembers is reset together
    // so a reset mid-entry or mid-reprogramming leaves no partial code and
    // also discards any reprogrammed password.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: entry shift register, digit counter, stored
    // password and the attempts counter. They are steered by the current
    // state so that enter is naturally ignored in every state not listed.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q    <= '0;
            count_q    <= '0;
            pass_q     <= DEFAULT_PASS;
            attempts_q <= ATT_MAX;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (enter) begin
                        entry_q <= entry_shifted;
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    entry_q <= '0;
                    count_q <= '0;
                    if (code_match) begin
                        attempts_q <= ATT_MAX;
                    end else begin
                        attempts_q <= attempts_q - 1'b1;
                    end
                end
                ST_SETPASS: begin
                    if (lock) begin
                        entry_q <= '0;
                        count_q <= '0;
                    end else if (enter) begin
                        if (last_digit) begin
                            pass_q  <= entry_shifted;
                            entry_q <= '0;
                            count_q <= '0;
                        end else begin
                            entry_q <= entry_shifted;
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_done) begin
                        attempts_q <= ATT_MAX;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic. A mismatch that uses up the final attempt goes
    // straight to LOCKOUT rather than through FAIL. In UNLOCKED, lock is
    // tested first so it wins over a simultaneous set_pass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enter) begin
                    state_d = last_digit ? ST_CHECK : ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (enter && last_digit) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (code_match) begin
                    state_d = ST_UNLOCKED;
                end else if (attempts_q == ATT_ONE) begin
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            ST_UNLOCKED: begin
                if (lock) begin
                    state_d = ST_IDLE;
                end else if (set_pass) begin
                    state_d = ST_SETPASS;
                end
            end
            ST_SETPASS: begin
                if (lock) begin
                    state_d = ST_IDLE;
                end else if (enter && last_digit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decodes straight from the state register; the password view is
    // the only output that also depends on an input.
    assign green_led     = (state_q == ST_UNLOCKED) || (state_q == ST_SETPASS);
    assign red_led       = (state_q == ST_FAIL) || (state_q == ST_LOCKOUT);
    assign alarm         = (state_q == ST_LOCKOUT);
    assign busy          = (state_q == ST_CHECK) || (state_q == ST_FAIL) ||
                           (state_q == ST_LOCKOUT);
    assign viewed_pass   = ((state_q == ST_UNLOCKED) && view_pass) ? pass_q : '0;
    assign attempts_left = attempts_q;

endmodule

// File: tb/tb_param_password_lock.sv
// ---------------------------------------------------------------------------
// tb_param_password_lock
//
// Self-checking bench for param_password_lock with default parameters and
// LOCKOUT_CYCLES=20. The reference model works at the level of whole codes:
// it remembers the stored password and the number of tries left and predicts
// the outcome of each complete code entry. Honours LOCKOUT_TIMER_EN.
// ---------------------------------------------------------------------------
module tb_param_password_lock;

    localparam int LOCK_CYC = 20;
    localparam int MAX_ATT  = 3;
    localparam int R_UNLOCK = 0;
    localparam int R_FAIL   = 1;
    localparam int R_LOCK   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digit;
    logic        enter;
    logic        set_pass;
    logic        view_pass;
    logic        lock;
    logic        green_led;
    logic        red_led;
    logic        alarm;
    logic [15:0] viewed_pass;
    logic [1:0]  attempts_left;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_pass;
    int          model_attempts;

    param_password_lock #(
        .DIGITS         (4),
        .DIGIT_W        (4),
        .MAX_ATTEMPTS   (MAX_ATT),
        .LOCKOUT_CYCLES (LOCK_CYC),
        .DEFAULT_PASS   (16'h1234)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .digit         (digit),
        .enter         (enter),
        .set_pass      (set_pass),
        .view_pass     (view_pass),
        .lock          (lock),
        .green_led     (green_led),
        .red_led       (red_led),
        .alarm         (alarm),
        .viewed_pass   (viewed_pass),
        .attempts_left (attempts_left),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_green"}, 32'(green_led), 32'd0);
        check_output({tag, "_red"},   32'(red_led),   32'd0);
        check_output({tag, "_alarm"}, 32'(alarm),     32'd0);
        check_output({tag, "_busy"},  32'(busy),      32'd0);
        check_output({tag, "_view"},  32'(viewed_pass), 32'd0);
    endtask

    // One key press: digit held with enter for a single cycle.
    task automatic apply_stimulus(input logic [3:0] d);
        digit = d;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic model_reset();
        model_pass     = 16'h1234;
        model_attempts = MAX_ATT;
    endtask

    task automatic do_reset();
        enter     = 1'b0;
        set_pass  = 1'b0;
        view_pass = 1'b0;
        lock      = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Enter a complete code and check the predicted outcome. With noisy set,
    // enter is held high with junk digits while the design is busy.
    task automatic enter_code(input logic [15:0] code, input bit noisy,
                              output int res);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(c[15:12]);
            c = c << 4;
            if (i < 3) begin
                check_output("entry_busy", 32'(busy), 32'd0);
                check_output("entry_green", 32'(green_led), 32'd0);
            end
        end
        check_output("check_busy", 32'(busy), 32'd1);
        check_output("check_red", 32'(red_led), 32'd0);
        if (noisy) begin
            enter = 1'b1;
            digit = 4'($urandom);
        end
        tick();
        if (code == model_pass) begin
            model_attempts = MAX_ATT;
            res = R_UNLOCK;
            check_output("unlock_green", 32'(green_led), 32'd1);
            check_output("unlock_red", 32'(red_led), 32'd0);
            check_output("unlock_attempts", 32'(attempts_left), 32'(model_attempts));
        end else begin
            model_attempts--;
            check_output("wrong_attempts", 32'(attempts_left), 32'(model_attempts));
            check_output("wrong_green", 32'(green_led), 32'd0);
            check_output("wrong_red", 32'(red_led), 32'd1);
            check_output("wrong_busy", 32'(busy), 32'd1);
            if (model_attempts == 0) begin
                res = R_LOCK;
                check_output("lockout_alarm", 32'(alarm), 32'd1);
            end else begin
                res = R_FAIL;
                check_output("fail_alarm", 32'(alarm), 32'd0);
                tick();
                enter = 1'b0;
                check_output("after_fail_red", 32'(red_led), 32'd0);
                check_output("after_fail_busy", 32'(busy), 32'd0);
            end
        end
        enter = 1'b0;
    endtask

    // Called one cycle into LOCKOUT. Leaves the design in IDLE with full
    // attempts, either by the timer or (permanent build) by a reset.
    task automatic wait_lockout();
`ifdef LOCKOUT_TIMER_EN
        for (int k = 1; k < LOCK_CYC; k++) begin
            enter = 1'($urandom_range(0, 1));
            digit = 4'($urandom);
            tick();
            check_output("lockout_hold_alarm", 32'(alarm), 32'd1);
        end
        enter = 1'b0;
        tick();
        check_idle("lockout_exit");
        check_output("lockout_exit_attempts", 32'(attempts_left), 32'(MAX_ATT));
        model_attempts = MAX_ATT;
`else
        for (int k = 0; k < 100; k++) begin
            enter = 1'($urandom_range(0, 1));
            digit = 4'($urandom);
            tick();
        end
        enter = 1'b0;
        check_output("lockout_perm_alarm", 32'(alarm), 32'd1);
        check_output("lockout_perm_red", 32'(red_led), 32'd1);
        do_reset();
        check_idle("lockout_reset");
        check_output("lockout_reset_attempts", 32'(attempts_left), 32'(MAX_ATT));
`endif
    endtask

    // Reprogram from UNLOCKED with a new four-digit code.
    task automatic reprogram(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        set_pass = 1'b1;
        tick();
        set_pass = 1'b0;
        check_output("setpass_green", 32'(green_led), 32'd1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(c[15:12]);
            c = c << 4;
            check_output("setpass_digit_green", 32'(green_led), (i < 3) ? 32'd1 : 32'd0);
        end
        model_pass = code;
    endtask

    task automatic do_lock();
        lock = 1'b1;
        tick();
        lock = 1'b0;
        check_output("lock_green", 32'(green_led), 32'd0);
    endtask

    initial begin
        int res;
        logic [15:0] code;

        digit     = 4'd0;
        enter     = 1'b0;
        set_pass  = 1'b0;
        view_pass = 1'b0;
        lock      = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        $display("[TB] reset released");

        check_idle("reset");
        check_output("reset_attempts", 32'(attempts_left), 32'd3);

        // Correct default code, then view and lock.
        enter_code(16'h1234, 1'b0, res);
        view_pass = 1'b1;
        #1;
        check_output("view_default", 32'(viewed_pass), 32'h1234);
        view_pass = 1'b0;
        #1;
        check_output("view_off", 32'(viewed_pass), 32'd0);
        do_lock();

        // Single wrong code, then recovery.
        enter_code(16'h4321, 1'b0, res);
        check_output("wrong_once_res", 32'(res), 32'(R_FAIL));
        enter_code(16'h1234, 1'b1, res);
        do_lock();

        // Three wrong codes with busy-time key noise give lockout.
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h5555, 1'b1, res);
        end
        check_output("lockout_res", 32'(res), 32'(R_LOCK));
        check_output("lockout_attempts", 32'(attempts_left), 32'd0);
        wait_lockout();

        // Reset a few cycles into a second lockout.
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h0000, 1'b0, res);
        end
        tick();
        tick();
        do_reset();
        check_idle("reset_in_lockout");
        check_output("reset_in_lockout_attempts", 32'(attempts_left), 32'd3);

        // set_pass / view_pass in IDLE are ignored.
        set_pass  = 1'b1;
        view_pass = 1'b1;
        tick();
        check_idle("idle_ignore");
        set_pass  = 1'b0;
        view_pass = 1'b0;
        enter_code(16'h1234, 1'b0, res);

        // enter ignored in UNLOCKED, then reprogram to 9876.
        apply_stimulus(4'($urandom));
        check_output("unlocked_enter_green", 32'(green_led), 32'd1);
        set_pass  = 1'b1;
        view_pass = 1'b1;
        tick();
        set_pass = 1'b0;
        check_output("setpass_view_blocked", 32'(viewed_pass), 32'd0);
        view_pass = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(4'(9 - i));
            check_output("reprog_green", 32'(green_led), (i < 3) ? 32'd1 : 32'd0);
        end
        model_pass = 16'h9876;
        enter_code(16'h1234, 1'b0, res);
        check_output("old_pass_res", 32'(res), 32'(R_FAIL));
        enter_code(16'h9876, 1'b0, res);
        check_output("new_pass_res", 32'(res), 32'(R_UNLOCK));
        view_pass = 1'b1;
        #1;
        check_output("view_new", 32'(viewed_pass), 32'h9876);

        // lock beats set_pass; SETPASS abort keeps the password.
        set_pass = 1'b1;
        lock     = 1'b1;
        tick();
        set_pass = 1'b0;
        lock     = 1'b0;
        check_idle("lock_wins");
        view_pass = 1'b0;
        enter_code(16'h9876, 1'b0, res);
        set_pass = 1'b1;
        tick();
        set_pass = 1'b0;
        apply_stimulus(4'h1);
        apply_stimulus(4'h1);
        do_lock();
        enter_code(16'h9876, 1'b0, res);
        check_output("abort_keeps_pass", 32'(res), 32'(R_UNLOCK));
        do_lock();

        // Reset mid-entry discards digits and the reprogrammed password.
        apply_stimulus(4'h9);
        apply_stimulus(4'h8);
        do_reset();
        enter_code(16'h1234, 1'b0, res);
        check_output("mid_reset_res", 32'(res), 32'(R_UNLOCK));
        do_lock();

        // Randomised sessions against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                code = model_pass;
            end else begin
                code = 16'($urandom);
            end
            enter_code(code, 1'($urandom_range(0, 1)), res);
            if (res == R_UNLOCK) begin
                if ($urandom_range(0, 3) == 0) begin
                    reprogram(16'($urandom));
                end else begin
                    do_lock();
                end
            end else if (res == R_LOCK) begin
                wait_lockout();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
